// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encoding for the execute-stage ALU
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_SLT  = 3'd3,
        OP_AND  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_OR   = 3'd7
    } alu_op_e;

    // Opcodes that drive the adder with an inverted B and a carry-in of 1.
    function automatic logic op_is_sub(input alu_op_e op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit full adder, the unit cell of the ripple chain
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/mux8.sv
// rtl/mux8.sv - eight-way result selector indexed directly by opcode value
module mux8
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [OP_W-1:0]  sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = in0;
        case (sel)
            3'd0: y = in0;
            3'd1: y = in1;
            3'd2: y = in2;
            3'd3: y = in3;
            3'd4: y = in4;
            3'd5: y = in5;
            3'd6: y = in6;
            3'd7: y = in7;
            default: y = in0;
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - registered ripple-carry ALU with zero/carry/overflow flags
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow
);

    alu_op_e          op_e;
    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;
    logic             ovf_raw;
    logic [WIDTH-1:0] slt_v;
    logic [WIDTH-1:0] mux_y;
    logic             is_arith;
    logic             uses_adder;
    logic             carry_n;
    logic             ovf_n;
    logic             zero_n;

    assign op_e = alu_op_e'(op);
    assign sub  = op_is_sub(op_e);
    assign bx   = b ^ {WIDTH{sub}};
    assign c[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (bx[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    // Signed less-than: the sign of a-b, corrected when the subtraction overflowed.
    assign ovf_raw = c[WIDTH-1] ^ c[WIDTH];
    assign slt_v   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};

    mux8 #(.WIDTH(WIDTH)) u_mux (
        .in0 (sum),
        .in1 (sum),
        .in2 (a ^ b),
        .in3 (slt_v),
        .in4 (a & b),
        .in5 (~(a & b)),
        .in6 (~(a | b)),
        .in7 (a | b),
        .sel (op),
        .y   (mux_y)
    );

    assign is_arith   = (op_e == OP_ADD) || (op_e == OP_SUB);
    assign uses_adder = is_arith || (op_e == OP_SLT);
    assign carry_n    = uses_adder & c[WIDTH];
    assign ovf_n      = is_arith & ovf_raw;
    assign zero_n     = ~|mux_y;

    // Result and flags hold across idle cycles; only out_valid tracks in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result    <= mux_y;
                carry_out <= carry_n;
                overflow  <= ovf_n;
                zero      <= zero_n;
            end
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - randomized and directed checks of alu_core against a behavioural model
module tb_alu_core;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    // Model of the registered outputs.
    logic         m_init = 1'b0;
    logic         m_valid = 1'b0;
    exp_t         m_e = '0;

    alu_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint sx, sy, s;
        logic [W:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e = '0;
        case (f)
            3'd0: begin
                u = {1'b0, x} + {1'b0, y};
                e.r = u[W-1:0];
                e.c = u[W];
                s = sx + sy;
                e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                e.r = x - y;
                e.c = (x >= y);
                s = sx - sy;
                e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: e.r = x ^ y;
            3'd3: begin
                e.r = (sx < sy) ? 1 : 0;
                e.c = (x >= y);
            end
            3'd4: e.r = x & y;
            3'd5: e.r = ~(x & y);
            3'd6: e.r = ~(x | y);
            default: e.r = x | y;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return W'($urandom_range(0, 7));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_init  <= 1'b1;
            m_valid <= 1'b0;
            m_e     <= '{r: '0, c: 1'b0, o: 1'b0, z: 1'b1};
        end else begin
            m_valid <= in_valid;
            if (in_valid)
                m_e <= model(op, a, b);
        end
    end

    // Every cycle after the first reset edge, the outputs must match the model.
    always @(negedge clk) begin
        if (m_init) begin
            chk("cyc_valid", 64'(out_valid), 64'(m_valid));
            chk("cyc_result", 64'(result), 64'(m_e.r));
            chk("cyc_flags", 64'({carry_out, overflow, zero}), 64'({m_e.c, m_e.o, m_e.z}));
        end
    end

    // Pins the model to a literal, then runs the op and compares the DUT to that literal.
    task automatic directed(input string name, input logic [2:0] f, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] er, input logic ec,
                            input logic eo, input logic ez);
        exp_t e;
        e = model(f, x, y);
        chk({name, "_model"}, 64'(e), 64'({er, ec, eo, ez}));
        op = f;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        chk({name, "_dut"}, 64'({out_valid, result, carry_out, overflow, zero}),
            64'({1'b1, er, ec, eo, ez}));
    endtask

    initial begin
        // Reset held two cycles while in_valid is asserted.
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b1;
        op = 3'd0;
        a = 32'h1234_5678;
        b = 32'h1111_1111;
        repeat (2) begin
            @(negedge clk);
            chk("reset_state", 64'({out_valid, result, carry_out, overflow, zero}),
                64'({1'b0, 32'h0, 1'b0, 1'b0, 1'b1}));
        end
        reset = 1'b0;

        directed("add_ovf",  3'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1);
        directed("sub_eq",   3'd1, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1'b1);
        directed("sub_ovf",  3'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        directed("slt_neg",  3'd3, 32'hFFFF_FFFE, 32'h3, 32'h1, 1'b1, 1'b0, 1'b0);
        directed("slt_pos",  3'd3, 32'h3, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 1'b1);
        directed("slt_ovf",  3'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0, 1'b0);
        directed("xor",  3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);
        directed("and",  3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        directed("nand", 3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0);
        directed("nor",  3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0, 1'b0);
        directed("or",   3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);

        // After the last back-to-back op, idle cycles must hold result and drop out_valid.
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h0;
        repeat (2) begin
            @(negedge clk);
            chk("hold", 64'({out_valid, result, carry_out, overflow, zero}),
                64'({1'b0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0}));
        end

        // Random traffic with idle gaps and occasional mid-stream resets.
        for (int i = 0; i < 2000; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            op       = 3'($urandom_range(0, 7));
            a        = pick_operand();
            b        = pick_operand();
            @(negedge clk);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
